// File: rtl/elevator_pkg.sv
`default_nettype none
// ============================================================================
// Module  : elevator_pkg
// Brief   : Shared floor encoding, direction codes and call-register states.
// Revision: 1.0 - initial release
// ============================================================================
package elevator_pkg;

    localparam int NUM_FLOORS = 3;
    localparam int FLOOR_W    = 2;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ARB  = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    localparam logic [NUM_FLOORS-1:0] FLOOR0_OH = 3'b001;
    localparam logic [NUM_FLOORS-1:0] FLOOR1_OH = 3'b010;
    localparam logic [NUM_FLOORS-1:0] FLOOR2_OH = 3'b100;

    // Out-of-range indices map to no floor at all.
    function automatic logic [NUM_FLOORS-1:0] floor_onehot(input logic [FLOOR_W-1:0] idx);
        case (idx)
            2'd0:    floor_onehot = FLOOR0_OH;
            2'd1:    floor_onehot = FLOOR1_OH;
            2'd2:    floor_onehot = FLOOR2_OH;
            default: floor_onehot = '0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/floor_call_register_btn_debounce.sv
`default_nettype none
// ============================================================================
// Module  : btn_debounce
// Brief   : 2-flop synchroniser, debounce counter and press pulse, one button.
// Revision: 1.0 - initial release
// ============================================================================
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic press
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_level;
    logic             r_press;
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_level <= 1'b0;
            r_press <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= btn_raw;
            r_sync2 <= r_sync1;
            r_press <= 1'b0;
            // Any sample matching the accepted level restarts the run count.
            if (r_sync2 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                r_cnt   <= '0;
                r_level <= r_sync2;
                r_press <= r_sync2;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign press = r_press;

endmodule
`default_nettype wire

// File: rtl/floor_call_register.sv
`default_nettype none
// ============================================================================
// Module  : floor_call_register
// Brief   : Debounces floor calls, latches pending calls and arbitrates one
//           held target floor. Optional HOLD watchdog: CALL_TIMEOUT_EN.
// Revision: 1.0 - initial release
// ============================================================================
module floor_call_register
    import elevator_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int TIMEOUT_CYCLES  = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_FLOORS-1:0] btn_raw,
    input  logic [FLOOR_W-1:0]    current_floor,
    input  logic                  door_open,
    input  logic                  direction,
    output logic [NUM_FLOORS-1:0] floor_req,
    output logic [NUM_FLOORS-1:0] pending,
    output logic                  req_valid,
    output logic                  call_at_floor,
    output logic                  req_timeout
);

    logic [1:0]            r_state;
    logic [FLOOR_W-1:0]    r_target;
    logic [NUM_FLOORS-1:0] r_pending;
    logic                  r_call_at_floor;

    logic [NUM_FLOORS-1:0] w_press;
    logic [NUM_FLOORS-1:0] w_cf_oh;
    logic [NUM_FLOORS-1:0] w_door_clr;
    logic [NUM_FLOORS-1:0] w_drop;
    logic [NUM_FLOORS-1:0] w_tmo_clr;
    logic                  w_tmo_hit;

    logic                  w_up_found;
    logic                  w_dn_found;
    logic [FLOOR_W-1:0]    w_up_idx;
    logic [FLOOR_W-1:0]    w_dn_idx;
    logic                  w_pick_valid;
    logic [FLOOR_W-1:0]    w_pick;

    for (genvar gi = 0; gi < NUM_FLOORS; gi++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_btn (
            .clk    (clk),
            .rst    (rst),
            .btn_raw(btn_raw[gi]),
            .press  (w_press[gi])
        );
    end

    assign w_cf_oh    = floor_onehot(current_floor);
    assign w_door_clr = door_open ? w_cf_oh : '0;
    // A door clear at the same floor outranks the drop report.
    assign w_drop     = (r_state == ST_IDLE) ? (w_press & w_cf_oh & ~w_door_clr) : '0;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_pending       <= '0;
            r_call_at_floor <= 1'b0;
        end else begin
            r_pending       <= (r_pending | (w_press & ~w_drop)) & ~w_door_clr & ~w_tmo_clr;
            r_call_at_floor <= |w_drop;
        end
    end

    // Nearest pending floor above and below the car.
    always_comb begin
        w_up_found = 1'b0;
        w_up_idx   = '0;
        w_dn_found = 1'b0;
        w_dn_idx   = '0;
        for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
            if (r_pending[i] && (i > int'(current_floor))) begin
                w_up_found = 1'b1;
                w_up_idx   = FLOOR_W'(i);
            end
        end
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (r_pending[i] && (i < int'(current_floor))) begin
                w_dn_found = 1'b1;
                w_dn_idx   = FLOOR_W'(i);
            end
        end
    end

    always_comb begin
        w_pick_valid = 1'b1;
        w_pick       = '0;
        if ((direction == DIR_UP) && w_up_found) begin
            w_pick = w_up_idx;
        end else if ((direction == DIR_DOWN) && w_dn_found) begin
            w_pick = w_dn_idx;
        end else if (w_up_found) begin
            w_pick = w_up_idx;
        end else if (w_dn_found) begin
            w_pick = w_dn_idx;
        end else begin
            w_pick_valid = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state  <= ST_IDLE;
            r_target <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (|r_pending) r_state <= ST_ARB;
                end
                ST_ARB: begin
                    if (w_pick_valid) begin
                        r_target <= w_pick;
                        r_state  <= ST_HOLD;
                    end else begin
                        r_state  <= ST_IDLE;
                    end
                end
                ST_HOLD: begin
                    if ((door_open && (current_floor == r_target)) || w_tmo_hit)
                        r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

`ifdef CALL_TIMEOUT_EN
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TMR_W-1:0] r_timer;
    logic             r_timeout;

    assign w_tmo_hit = (r_state == ST_HOLD) && (r_timer == TMR_W'(TIMEOUT_CYCLES - 1));
    assign w_tmo_clr = w_tmo_hit ? floor_onehot(r_target) : '0;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_timer   <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_timer <= (r_state == ST_HOLD) ? r_timer + 1'b1 : '0;
            if (w_tmo_hit) r_timeout <= 1'b1;
        end
    end

    assign req_timeout = r_timeout;
`else
    assign w_tmo_hit   = 1'b0;
    assign w_tmo_clr   = '0;
    assign req_timeout = 1'b0;
`endif

    assign floor_req     = (r_state == ST_HOLD) ? floor_onehot(r_target) : '0;
    assign req_valid     = |floor_req;
    assign pending       = r_pending;
    assign call_at_floor = r_call_at_floor;

endmodule
`default_nettype wire

// File: tb/tb_floor_call_register.sv
`default_nettype none
// ============================================================================
// Module  : tb_floor_call_register
// Brief   : Directed self-checking bench for floor_call_register.
// Revision: 1.0 - initial release
// ============================================================================
module tb_floor_call_register;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] btn_raw;
    logic [1:0] current_floor;
    logic       door_open;
    logic       direction;
    logic [2:0] floor_req;
    logic [2:0] pending;
    logic       req_valid;
    logic       call_at_floor;
    logic       req_timeout;

    int total = 0;
    int bad   = 0;

    floor_call_register #(
        .DEBOUNCE_CYCLES(4),
        .TIMEOUT_CYCLES (10)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .btn_raw      (btn_raw),
        .current_floor(current_floor),
        .door_open    (door_open),
        .direction    (direction),
        .floor_req    (floor_req),
        .pending      (pending),
        .req_valid    (req_valid),
        .call_at_floor(call_at_floor),
        .req_timeout  (req_timeout)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Raw high for 6 cycles, then low long enough to debounce the release.
    // Pending sets on the 7th edge; returns after the 12th edge.
    task automatic press(input logic [2:0] mask);
        btn_raw = mask;
        tick(6);
        btn_raw = 3'b000;
        tick(6);
    endtask

    int   rises;
    logic prev_p1;
    logic seen_tmo;

    initial begin
        rst           = 1'b0;
        btn_raw       = 3'b111;
        current_floor = 2'd3;
        door_open     = 1'b0;
        direction     = 1'b1;

        // 1: reset with all buttons held
        tick(3);
        chk("rst_pending",   {5'b0, pending},   8'h00);
        chk("rst_floor_req", {5'b0, floor_req}, 8'h00);
        chk("rst_req_valid", {7'b0, req_valid}, 8'h00);
        chk("rst_call_at",   {7'b0, call_at_floor}, 8'h00);
        chk("rst_timeout",   {7'b0, req_timeout},   8'h00);
        rst = 1'b1;
        tick(6);
        chk("t1_pending_early", {5'b0, pending}, 8'h00);
        tick(1);
        chk("t1_pending_7", {5'b0, pending}, 8'h07);
        tick(2);
        chk("t1_floor_req", {5'b0, floor_req}, 8'h04);
        rst     = 1'b0;
        btn_raw = 3'b000;
        tick(3);
        chk("t1_rerst_pending", {5'b0, pending}, 8'h00);
        rst = 1'b1;
        tick(2);

        // 2: single call above, then served
        current_floor = 2'd0;
        direction     = 1'b1;
        btn_raw       = 3'b100;
        tick(6);
        btn_raw = 3'b000;
        chk("t2_pending_6", {5'b0, pending}, 8'h00);
        tick(1);
        chk("t2_pending_7", {5'b0, pending}, 8'h04);
        tick(1);
        chk("t2_floor_req_arb", {5'b0, floor_req}, 8'h00);
        tick(1);
        chk("t2_floor_req", {5'b0, floor_req}, 8'h04);
        chk("t2_req_valid", {7'b0, req_valid}, 8'h01);
        current_floor = 2'd2;
        door_open     = 1'b1;
        tick(1);
        door_open = 1'b0;
        chk("t2_served_pending", {5'b0, pending},   8'h00);
        chk("t2_served_req",     {5'b0, floor_req}, 8'h00);
        chk("t2_served_valid",   {7'b0, req_valid}, 8'h00);
        tick(6);

        // 3: bouncing button never registers, steady hold registers once
        rises   = 0;
        prev_p1 = pending[1];
        for (int k = 0; k < 10; k++) begin
            btn_raw[1] = ~btn_raw[1];
            for (int j = 0; j < 2; j++) begin
                tick(1);
                if (pending[1] && !prev_p1) rises++;
                prev_p1 = pending[1];
            end
        end
        chk("t3_bounce_pending", {5'b0, pending}, 8'h00);
        btn_raw[1] = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick(1);
            if (pending[1] && !prev_p1) rises++;
            prev_p1 = pending[1];
        end
        chk("t3_one_set", rises[7:0], 8'h01);
        chk("t3_pending", {5'b0, pending}, 8'h02);
        chk("t3_floor_req_down", {5'b0, floor_req}, 8'h02);
        current_floor = 2'd1;
        door_open     = 1'b1;
        tick(1);
        door_open = 1'b0;
        tick(8);
        chk("t3_held_no_refire", {5'b0, pending}, 8'h00);
        btn_raw = 3'b000;
        tick(6);

        // 4: door at a non-target floor clears only that call
        current_floor = 2'd0;
        direction     = 1'b1;
        press(3'b100);
        chk("t4_target2", {5'b0, floor_req}, 8'h04);
        press(3'b010);
        chk("t4_pending_110", {5'b0, pending}, 8'h06);
        current_floor = 2'd1;
        door_open     = 1'b1;
        tick(1);
        door_open = 1'b0;
        chk("t4_pending_100", {5'b0, pending},   8'h04);
        chk("t4_req_kept",    {5'b0, floor_req}, 8'h04);
        current_floor = 2'd2;
        door_open     = 1'b1;
        tick(1);
        door_open = 1'b0;
        chk("t4_done_pending", {5'b0, pending},   8'h00);
        chk("t4_done_req",     {5'b0, floor_req}, 8'h00);

        // 5: call at the car's own floor, and clear beating a set
        current_floor = 2'd1;
        btn_raw       = 3'b010;
        tick(6);
        chk("t5_call_at_early", {7'b0, call_at_floor}, 8'h00);
        tick(1);
        chk("t5_call_at_pulse", {7'b0, call_at_floor}, 8'h01);
        chk("t5_pending_0",     {5'b0, pending},       8'h00);
        tick(1);
        chk("t5_call_at_once",  {7'b0, call_at_floor}, 8'h00);
        btn_raw = 3'b000;
        tick(6);
        current_floor = 2'd0;
        btn_raw       = 3'b001;
        tick(6);
        door_open = 1'b1;
        tick(1);
        door_open = 1'b0;
        chk("t5_clr_wins",      {5'b0, pending},       8'h00);
        chk("t5_clr_no_callat", {7'b0, call_at_floor}, 8'h00);
        btn_raw = 3'b000;
        tick(6);
        chk("t5_still_empty", {5'b0, pending}, 8'h00);

        // Direction down: lower call first, then reversal to the upper one
        current_floor = 2'd1;
        direction     = 1'b0;
        press(3'b101);
        chk("dn_pending", {5'b0, pending},   8'h05);
        chk("dn_pick_0",  {5'b0, floor_req}, 8'h01);
        current_floor = 2'd0;
        door_open     = 1'b1;
        tick(1);
        door_open = 1'b0;
        chk("dn_after_0", {5'b0, floor_req}, 8'h00);
        tick(2);
        chk("dn_reverse_2", {5'b0, floor_req}, 8'h04);
        current_floor = 2'd2;
        door_open     = 1'b1;
        tick(1);
        door_open = 1'b0;
        chk("dn_done", {5'b0, pending}, 8'h00);

        // 6: HOLD without door_open
        current_floor = 2'd0;
        direction     = 1'b1;
        press(3'b100);
`ifdef CALL_TIMEOUT_EN
        tick(6);
        chk("t6_tmo_early", {7'b0, req_timeout}, 8'h00);
        tick(1);
        chk("t6_tmo_set",   {7'b0, req_timeout}, 8'h01);
        chk("t6_tmo_req",   {5'b0, floor_req},   8'h00);
        chk("t6_tmo_pend",  {5'b0, pending},     8'h00);
`else
        seen_tmo = 1'b0;
        for (int k = 0; k < 300; k++) begin
            tick(1);
            if (req_timeout) seen_tmo = 1'b1;
        end
        chk("t6_no_timeout", {7'b0, seen_tmo},  8'h00);
        chk("t6_still_hold", {5'b0, floor_req}, 8'h04);
`endif

        // Reset mid-HOLD drops target and pending calls
        press(3'b010);
        rst = 1'b0;
        tick(1);
        chk("midrst_req",     {5'b0, floor_req}, 8'h00);
        chk("midrst_pending", {5'b0, pending},   8'h00);
        chk("midrst_timeout", {7'b0, req_timeout}, 8'h00);
        rst = 1'b1;
        tick(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
